// File: rtl/uart_pkg.sv
// Shared UART constants: baud encodings, oversampling window and divider helpers.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 6;
  localparam int unsigned SAMPLE_HI  = 12;
  localparam int unsigned MAJORITY   = 4;   // 4 of the 7 window samples decide the bit
  localparam int unsigned BPS_W      = 8;   // tick counter width, 0..159

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  // Baud rate in bits/s for an encoding; unused codes fall back to 9600.
  function automatic int unsigned baud_rate(input logic [2:0] sel);
    case (sel)
      BAUD_19200:  return 19_200;
      BAUD_38400:  return 38_400;
      BAUD_57600:  return 57_600;
      BAUD_115200: return 115_200;
      default:     return 9_600;
    endcase
  endfunction

  // Clocks per oversample tick, rounded down.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [2:0] sel);
    return clk_freq / (OVERSAMPLE * baud_rate(sel));
  endfunction

  // Counter width able to hold the slowest divider.
  function automatic int unsigned div_width(input int unsigned clk_freq);
    return $clog2(baud_div(clk_freq, BAUD_9600) + 1);
  endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Oversample tick generator: counts 0..DIV-1 and flags the last count.
module uart_rx_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [2:0] i_baud_sel,
  output logic       o_tick_c
);

  localparam int unsigned DIV_W = div_width(CLK_FREQ);

  localparam logic [DIV_W-1:0] TOP_9600   = DIV_W'(baud_div(CLK_FREQ, BAUD_9600) - 1);
  localparam logic [DIV_W-1:0] TOP_19200  = DIV_W'(baud_div(CLK_FREQ, BAUD_19200) - 1);
  localparam logic [DIV_W-1:0] TOP_38400  = DIV_W'(baud_div(CLK_FREQ, BAUD_38400) - 1);
  localparam logic [DIV_W-1:0] TOP_57600  = DIV_W'(baud_div(CLK_FREQ, BAUD_57600) - 1);
  localparam logic [DIV_W-1:0] TOP_115200 = DIV_W'(baud_div(CLK_FREQ, BAUD_115200) - 1);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_top;

  // Terminal count for the latched baud setting.
  always_comb begin
    w_top = TOP_9600;
    case (i_baud_sel)
      BAUD_19200:  w_top = TOP_19200;
      BAUD_38400:  w_top = TOP_38400;
      BAUD_57600:  w_top = TOP_57600;
      BAUD_115200: w_top = TOP_115200;
      default:     w_top = TOP_9600;
    endcase
  end

  assign o_tick_c = i_en && (r_cnt == w_top);

  // Divider counter; clear wins so each frame starts phase-aligned to its start edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick_c ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and 7-sample majority vote per bit.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Rs232_Rx,
  input  logic [2:0] baud_set,
  output logic [7:0] data_byte,
  output logic       Rx_Done,
  output logic       frame_err,
  output logic       uart_state
);

  rx_state_e        r_state;
  logic             r_sync0;
  logic             r_sync1;
  logic             r_edge;
  logic [2:0]       r_baud;
  logic [BPS_W-1:0] r_bps_cnt;
  logic [2:0]       r_acc;
  logic [7:0]       r_shift;

  logic       w_fall;
  logic       w_start;
  logic       w_en;
  logic       w_tick;
  logic       w_win;
  logic       w_eval;
  logic       w_bit;
  logic [3:0] w_k;
  logic [3:0] w_b;
  logic [2:0] w_sum;

  assign w_fall  = r_edge & ~r_sync1;
  assign w_start = (r_state == RX_IDLE) & w_fall;
  assign w_en    = (r_state == RX_RECV);
  assign w_k     = r_bps_cnt[3:0];
  assign w_b     = r_bps_cnt[7:4];
  assign w_win   = (w_k >= 4'(SAMPLE_LO)) && (w_k <= 4'(SAMPLE_HI));
  assign w_eval  = w_tick && (w_k == 4'(SAMPLE_HI));
  // Last window sample is folded in combinationally so the decision lands on k=12.
  assign w_sum   = r_acc + {2'b00, r_sync1};
  assign w_bit   = (w_sum >= 3'(MAJORITY));

  uart_rx_baud_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_baud_gen (
    .i_clk      (Clk),
    .i_rst_n    (Rst_n),
    .i_clr      (w_start),
    .i_en       (w_en),
    .i_baud_sel (r_baud),
    .o_tick_c   (w_tick)
  );

  // Synchronizer, receive FSM, majority accumulator and shift register.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_sync0    <= 1'b1;
      r_sync1    <= 1'b1;
      r_edge     <= 1'b1;
      r_state    <= RX_IDLE;
      uart_state <= 1'b0;
      r_baud     <= '0;
      r_bps_cnt  <= '0;
      r_acc      <= '0;
      r_shift    <= '0;
      data_byte  <= '0;
      Rx_Done    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_sync0   <= Rs232_Rx;
      r_sync1   <= r_sync0;
      r_edge    <= r_sync1;
      Rx_Done   <= 1'b0;
      frame_err <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (w_fall) begin
            r_state    <= RX_RECV;
            uart_state <= 1'b1;
            r_baud     <= baud_set;
            r_bps_cnt  <= '0;
            r_acc      <= '0;
          end
        end

        RX_RECV: begin
          if (w_tick) begin
            r_bps_cnt <= r_bps_cnt + BPS_W'(1);
            if (w_win) begin
              r_acc <= w_sum;
            end
            if (w_eval) begin
              r_acc <= '0;
              if (w_b == 4'd0) begin
                // Start bit voted high: treat as a line glitch.
                if (w_bit) begin
                  r_state    <= RX_IDLE;
                  uart_state <= 1'b0;
                end
              end else if (w_b <= 4'd8) begin
                r_shift <= {w_bit, r_shift[7:1]};
              end else begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                r_state    <= RX_IDLE;
                uart_state <= 1'b0;
                if (w_bit) begin
                  data_byte <= r_shift;
                  Rx_Done   <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
              end
            end
          end
        end

        default: begin
          r_state    <= RX_IDLE;
          uart_state <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Bench for uart_byte_rx: serial line driver, result model and pulse monitor.
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ = 10_000_000;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Rs232_Rx;
  logic [2:0] baud_set;
  logic [7:0] data_byte;
  logic       Rx_Done;
  logic       frame_err;
  logic       uart_state;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Rs232_Rx   (Rs232_Rx),
    .baud_set   (baud_set),
    .data_byte  (data_byte),
    .Rx_Done    (Rx_Done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference divider from the baud table.
  function automatic int ref_div(input int sel);
    int baud;
    case (sel)
      1:       baud = 19200;
      2:       baud = 38400;
      3:       baud = 57600;
      4:       baud = 115200;
      default: baud = 9600;
    endcase
    return CLK_FREQ / (16 * baud);
  endfunction

  // Monitor state
  int         cyc = 0;
  logic       rst_q = 1'b0;
  int         n_done = 0, n_ferr = 0, n_both = 0, n_wide = 0, n_unstable = 0, n_st_rise = 0;
  int         done_cyc = 0, st_rise_cyc = 0, st_len = 0, edge_cyc = 0;
  logic       p_done = 1'b0, p_ferr = 1'b0, p_st = 1'b0;
  logic [7:0] p_byte = 8'h00;
  logic [7:0] exp_byte = 8'h00;

  always @(posedge Clk) begin
    cyc   <= cyc + 1;
    rst_q <= Rst_n;
  end

  // Pulse counting and output-stability bookkeeping.
  always @(negedge Clk) begin
    if (Rx_Done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (frame_err) n_ferr++;
    if (Rx_Done && frame_err) n_both++;
    if ((Rx_Done && p_done) || (frame_err && p_ferr)) n_wide++;
    if (rst_q && !Rx_Done && (data_byte !== p_byte)) n_unstable++;
    if (uart_state && !p_st) begin
      st_rise_cyc = cyc;
      st_len      = 0;
      n_st_rise++;
    end
    if (uart_state) st_len++;
    p_done = Rx_Done;
    p_ferr = frame_err;
    p_st   = uart_state;
    p_byte = data_byte;
  end

  // Serial transmitter model; cut>0 abandons the frame after that many clocks.
  task automatic send_frame(input logic [7:0] b, input logic [2:0] sel, input logic stop,
                            input int per, input bit noise, input int cut, input bit chg_baud);
    logic [9:0] bits;
    int div;
    int n;
    bits     = {stop, b, 1'b0};
    div      = ref_div(int'(sel));
    baud_set = sel;
    n        = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < per; c++) begin
        @(posedge Clk);
        #1;
        if (cut > 0 && n == cut) return;
        Rs232_Rx = bits[i] ^ (noise && i >= 1 && i <= 8 &&
                              (c == 8 * div + 2 || c == 11 * div + 2));
        if (i == 0 && c == 0) edge_cyc = cyc;
        if (chg_baud && i == 3 && c == 0) baud_set = 3'($urandom_range(0, 7));
        n++;
      end
    end
  endtask

  // One frame checked against the model: good stop updates the byte, bad stop flags an error.
  task automatic run_frame(input string tag, input logic [7:0] b, input logic [2:0] sel,
                           input logic stop, input int per, input bit noise, input bit chg);
    int d0;
    int f0;
    d0 = n_done;
    f0 = n_ferr;
    send_frame(b, sel, stop, per, noise, 0, chg);
    Rs232_Rx = 1'b1;
    repeat (4 * ref_div(int'(sel)) + 8) @(posedge Clk);
    if (stop) exp_byte = b;
    @(negedge Clk);
    chk({tag, "_done"}, n_done - d0, stop ? 1 : 0);
    chk({tag, "_ferr"}, n_ferr - f0, stop ? 0 : 1);
    chk({tag, "_byte"}, data_byte, exp_byte);
  endtask

  initial begin
    repeat (90_000) @(posedge Clk);
    $display("FAIL watchdog: cycle budget exhausted at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    int div;
    int lat;
    logic [7:0] b;
    logic [2:0] sel;
    logic stp;

    Rst_n    = 1'b0;
    Rs232_Rx = 1'b1;
    baud_set = 3'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_byte",  data_byte,  0);
    chk("rst_done",  Rx_Done,    0);
    chk("rst_ferr",  frame_err,  0);
    chk("rst_state", uart_state, 0);
    Rst_n = 1'b1;
    repeat (20) @(posedge Clk);

    // Baseline at 9600 with latency checks
    div = ref_div(0);
    run_frame("base", 8'h55, 3'd0, 1'b1, 16 * div, 0, 0);
    lat = done_cyc - edge_cyc;
    chk("base_lat", (lat >= 157 * div + 3) && (lat <= 157 * div + 5), 1);
    chk("base_st_lat", st_rise_cyc - edge_cyc, 3);
    chk("base_st_len", (st_len >= 157 * div - 2) && (st_len <= 157 * div + 2), 1);

    // Back-to-back at 115200, no idle between frames
    div = ref_div(4);
    d0  = n_done;
    send_frame(8'hA3, 3'd4, 1'b1, 16 * div, 0, 0, 0);
    @(negedge Clk);
    chk("b2b_first", data_byte, 8'hA3);
    send_frame(8'h0F, 3'd4, 1'b1, 16 * div, 0, 0, 0);
    repeat (4 * div + 8) @(posedge Clk);
    @(negedge Clk);
    chk("b2b_done", n_done - d0, 2);
    chk("b2b_second", data_byte, 8'h0F);
    exp_byte = 8'h0F;

    // Start glitch of 3 ticks
    div      = ref_div(0);
    d0       = n_done;
    r0       = n_st_rise;
    baud_set = 3'd0;
    @(posedge Clk);
    #1 Rs232_Rx = 1'b0;
    repeat (3 * div) @(posedge Clk);
    #1 Rs232_Rx = 1'b1;
    repeat (20 * div) @(posedge Clk);
    @(negedge Clk);
    chk("glitch_rise", n_st_rise - r0, 1);
    chk("glitch_len", (st_len > 0) && (st_len <= 13 * div + 1), 1);
    chk("glitch_state", uart_state, 0);
    chk("glitch_done", n_done - d0, 0);
    chk("glitch_byte", data_byte, exp_byte);

    // Framing error, noise injection and fast sender
    run_frame("ferr", 8'h3C, 3'd2, 1'b0, 16 * ref_div(2), 0, 0);
    run_frame("noise", 8'h96, 3'd1, 1'b1, 16 * ref_div(1), 1, 0);
    run_frame("fast", 8'h96, 3'd1, 1'b1, (16 * ref_div(1) * 975) / 1000, 0, 0);

    // Reset in the middle of data bit 4
    div = ref_div(3);
    d0  = n_done;
    send_frame(8'h5A, 3'd3, 1'b1, 16 * div, 0, 5 * 16 * div + 8 * div, 0);
    chk("rstmid_busy", uart_state, 1);
    Rs232_Rx = 1'b1;
    Rst_n    = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("rstmid_byte",  data_byte,  0);
    chk("rstmid_done",  Rx_Done,    0);
    chk("rstmid_ferr",  frame_err,  0);
    chk("rstmid_state", uart_state, 0);
    Rst_n    = 1'b1;
    exp_byte = 8'h00;
    repeat (2 * 16 * div) @(posedge Clk);
    chk("rstmid_dropped", n_done - d0, 0);
    run_frame("rst_e7", 8'hE7, 3'd3, 1'b1, 16 * div, 0, 0);

    // Loopback-style frame from a transmitter at the shared 9600 setting
    run_frame("loop", 8'h81, 3'd0, 1'b1, 16 * ref_div(0), 0, 0);

    // Random frames, some with bad stop bits and mid-frame baud changes
    for (int i = 0; i < 4; i++) begin
      b   = 8'($urandom);
      sel = 3'($urandom_range(1, 4));
      stp = ($urandom_range(0, 3) != 0);
      run_frame($sformatf("rnd%0d", i), b, sel, stp, 16 * ref_div(int'(sel)), 0, i[0]);
    end

    chk("excl", n_both, 0);
    chk("width", n_wide, 0);
    chk("stable", n_unstable, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
